// File: rtl/clock_time_set_ctrl.sv
// Time-set sequencer for the 24-hour clock: snapshot the running time, edit h/m/s
// with inc/dec buttons (with auto-repeat), then strobe Timeset to load the edited value.
module clock_time_set_ctrl #(
   parameter int LOAD_CYCLES   = 2,
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       mode_btn_i,
   input  logic       inc_btn_i,
   input  logic       dec_btn_i,
   input  logic       cancel_i,
   input  logic [4:0] cur_hour_i,
   input  logic [5:0] cur_min_i,
   input  logic [5:0] cur_sec_i,
   output logic       Timeset,
   output logic [4:0] Hourset,
   output logic [5:0] Minset,
   output logic [5:0] Secset,
   output logic [1:0] field_o,
   output logic       busy_o
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam int LD_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SET_HR,
      SET_MIN,
      SET_SEC,
      LOAD
   } state_t;

   state_t            state_q, state_d;
   logic              mode_q, inc_q, dec_q, cancel_q;
   logic              mode_edge, inc_edge, dec_edge, cancel_edge;
   logic              both_high, in_set;
   logic [LD_W-1:0]   load_cnt_q, load_cnt_d;
   logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d, cnt_inc;
   logic              rpt_armed_q, rpt_armed_d;
   logic              rpt_phase_q, rpt_phase_d;
   logic              step_up, step_dn;
   logic [4:0]        hour_d;
   logic [5:0]        min_d, sec_d;

   assign mode_edge   = mode_btn_i & ~mode_q;
   assign inc_edge    = inc_btn_i  & ~inc_q;
   assign dec_edge    = dec_btn_i  & ~dec_q;
   assign cancel_edge = cancel_i   & ~cancel_q;
   assign both_high   = inc_btn_i & dec_btn_i;
   assign in_set      = (state_q == SET_HR) || (state_q == SET_MIN) || (state_q == SET_SEC);

   // Sequencing: cancel outranks mode; LOAD ignores every button until it times out.
   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      case (state_q)
         IDLE:    if (mode_edge) state_d = SET_HR;
         SET_HR:  if (cancel_edge) state_d = IDLE; else if (mode_edge) state_d = SET_MIN;
         SET_MIN: if (cancel_edge) state_d = IDLE; else if (mode_edge) state_d = SET_SEC;
         SET_SEC: if (cancel_edge) state_d = IDLE; else if (mode_edge) state_d = LOAD;
         LOAD: begin
            if (load_cnt_q == LD_W'(LOAD_CYCLES - 1)) begin
               state_d    = IDLE;
               load_cnt_d = '0;
            end else begin
               load_cnt_d = load_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Step generation: an edge steps immediately and arms the repeat timer; the timer
   // only runs while that one button stays held in the same editing state.
   always_comb begin
      step_up     = 1'b0;
      step_dn     = 1'b0;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_armed_d = rpt_armed_q;
      rpt_phase_d = rpt_phase_q;
      cnt_inc     = rpt_cnt_q + 1'b1;
      if (!in_set || (state_d != state_q) || both_high || !(inc_btn_i || dec_btn_i)) begin
         rpt_cnt_d   = '0;
         rpt_armed_d = 1'b0;
         rpt_phase_d = 1'b0;
      end else if (inc_edge || dec_edge) begin
         step_up     = inc_edge;
         step_dn     = dec_edge;
         rpt_cnt_d   = '0;
         rpt_armed_d = 1'b1;
         rpt_phase_d = 1'b0;
      end else if (rpt_armed_q) begin
         if (!rpt_phase_q && (cnt_inc == RPT_W'(REPEAT_DELAY))) begin
            step_up     = inc_btn_i;
            step_dn     = dec_btn_i;
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b1;
         end else if (rpt_phase_q && (cnt_inc == RPT_W'(REPEAT_PERIOD))) begin
            step_up   = inc_btn_i;
            step_dn   = dec_btn_i;
            rpt_cnt_d = '0;
         end else begin
            rpt_cnt_d = cnt_inc;
         end
      end
   end

   // Field values: snapshot with range clamp on entry, wrap-around edits afterwards.
   always_comb begin
      hour_d = Hourset;
      min_d  = Minset;
      sec_d  = Secset;
      if ((state_q == IDLE) && mode_edge) begin
         hour_d = (cur_hour_i > 5'd23) ? 5'd0 : cur_hour_i;
         min_d  = (cur_min_i  > 6'd59) ? 6'd0 : cur_min_i;
         sec_d  = (cur_sec_i  > 6'd59) ? 6'd0 : cur_sec_i;
      end else begin
         case (state_q)
            SET_HR: begin
               if (step_up)      hour_d = (Hourset == 5'd23) ? 5'd0  : Hourset + 5'd1;
               else if (step_dn) hour_d = (Hourset == 5'd0)  ? 5'd23 : Hourset - 5'd1;
            end
            SET_MIN: begin
               if (step_up)      min_d = (Minset == 6'd59) ? 6'd0  : Minset + 6'd1;
               else if (step_dn) min_d = (Minset == 6'd0)  ? 6'd59 : Minset - 6'd1;
            end
            SET_SEC: begin
               if (step_up)      sec_d = (Secset == 6'd59) ? 6'd0  : Secset + 6'd1;
               else if (step_dn) sec_d = (Secset == 6'd0)  ? 6'd59 : Secset - 6'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      field_o = 2'd0;
      case (state_q)
         SET_HR:  field_o = 2'd1;
         SET_MIN: field_o = 2'd2;
         SET_SEC: field_o = 2'd3;
         default: field_o = 2'd0;
      endcase
   end

   assign busy_o = (state_q != IDLE);

   // Button history resets to 1 so a button held through reset must be re-pressed.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         load_cnt_q  <= '0;
         rpt_cnt_q   <= '0;
         rpt_armed_q <= 1'b0;
         rpt_phase_q <= 1'b0;
         mode_q      <= 1'b1;
         inc_q       <= 1'b1;
         dec_q       <= 1'b1;
         cancel_q    <= 1'b1;
         Timeset     <= 1'b0;
         Hourset     <= 5'd0;
         Minset      <= 6'd0;
         Secset      <= 6'd0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_armed_q <= rpt_armed_d;
         rpt_phase_q <= rpt_phase_d;
         mode_q      <= mode_btn_i;
         inc_q       <= inc_btn_i;
         dec_q       <= dec_btn_i;
         cancel_q    <= cancel_i;
         Timeset     <= (state_d == LOAD);
         Hourset     <= hour_d;
         Minset      <= min_d;
         Secset      <= sec_d;
      end
   end

endmodule
